// File: rtl/mire_pkg.sv
// mire_pkg: colour constants, pixel type and writer FSM states shared by the mire writer
package mire_pkg;
  typedef logic [23:0] rgb_t;
  localparam rgb_t WHITE = 24'hFFFFFF;
  localparam rgb_t BAR [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
  typedef enum logic [1:0] {IDLE, BURST, PAUSE} mire_state_t;
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone bus shared by the frame-buffer masters, the arbiter and the SDRAM controller
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic [2:0]  cti;
  logic [1:0]  bte;
  modport master (input clk, rst, ack, dat_sm, output adr, dat_ms, sel, we, cyc, stb, cti, bte);
  modport slave (input clk, rst, adr, dat_ms, sel, we, cyc, stb, cti, bte, output ack, dat_sm);
endinterface

// File: rtl/mire_pattern.sv
// mire_pattern: walks x/y/bar counters and registers the colour of the pixel about to be written
module mire_pattern
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int GRID  = 16
) (
  input  logic                    pixel_clk,
  input  logic                    pixel_rst,
  input  logic                    advance,
  input  logic [$clog2(GRID)-1:0] off,
  output rgb_t                    rgb,
  output logic                    last_pixel
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int OW = $clog2(GRID);
  localparam int BARW = HDISP / 8;
  localparam int CW = BARW > 1 ? $clog2(BARW) : 1;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [CW-1:0] col, ncol;
  logic [2:0] bar, nbar;
  logic x_end, y_end, col_end, grid, nlast;
  rgb_t nrgb;
  always_comb begin
    x_end = x == XW'(HDISP - 1);
    y_end = y == YW'(VDISP - 1);
    col_end = col == CW'(BARW - 1);
    nx = x_end ? '0 : x + XW'(1);
    ny = x_end ? (y_end ? '0 : y + YW'(1)) : y;
    ncol = x_end || col_end ? '0 : col + CW'(1);
    nbar = x_end ? 3'd0 : col_end ? bar + 3'd1 : bar;
    grid = OW'(nx[OW-1:0] + off) == '0 || ny[OW-1:0] == '0;
    nrgb = grid ? WHITE : BAR[nbar];
    nlast = nx == XW'(HDISP - 1) && ny == YW'(VDISP - 1);
  end
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      x <= '0;
      y <= '0;
      col <= '0;
      bar <= 3'd0;
      rgb <= WHITE;
      last_pixel <= 1'b0;
    end else if (advance) begin
      x <= nx;
      y <= ny;
      col <= ncol;
      bar <= nbar;
      rgb <= nrgb;
      last_pixel <= nlast;
    end
  end
endmodule

// File: rtl/mire_writer.sv
// mire_writer: Wishbone burst writer filling the frame buffer with a grid/bar test pattern; MIRE_MOVING_EN scrolls the grid
module mire_writer
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GAP   = 16,
  parameter int GRID  = 16
) (
  wshb_if.master wshb_ifm,
  output logic   frame_done
);
  localparam int NPIX = HDISP * VDISP;
  localparam int PW = $clog2(NPIX);
  localparam int BW = $clog2(BURST);
  localparam int GW = $clog2(GAP + 1);
  localparam int OW = $clog2(GRID);
  mire_state_t state, nxt;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [GW-1:0] gcnt;
  logic [PW-1:0] p, p_d;
  logic [OW-1:0] off;
  logic [2:0] cti, cti_d;
  logic cyc, accept, last_pixel;
  rgb_t rgb;
  logic unused_dat_sm;
  assign unused_dat_sm = ^wshb_ifm.dat_sm;
  assign accept = cyc & wshb_ifm.ack;
  always_comb begin
    nxt = state == mire_pkg::IDLE ? mire_pkg::BURST
        : state == mire_pkg::PAUSE ? (gcnt == GW'(GAP - 1) ? mire_pkg::BURST : mire_pkg::PAUSE)
        : accept && (bcnt == BW'(BURST - 1) || last_pixel) ? mire_pkg::PAUSE : mire_pkg::BURST;
    bcnt_d = nxt == mire_pkg::BURST && state != mire_pkg::BURST ? '0 : accept ? bcnt + BW'(1) : bcnt;
    p_d = accept ? (last_pixel ? '0 : p + PW'(1)) : p;
    cti_d = bcnt_d == BW'(BURST - 1) || p_d == PW'(NPIX - 1) ? 3'b111 : 3'b010;
  end
  // cyc is held low in the first BURST cycle after IDLE, giving the 2-cycle start latency
  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      state <= mire_pkg::IDLE;
      bcnt <= '0;
      gcnt <= '0;
      p <= '0;
      cyc <= 1'b0;
      cti <= 3'b010;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      bcnt <= bcnt_d;
      gcnt <= state == mire_pkg::PAUSE ? gcnt + GW'(1) : '0;
      p <= p_d;
      cyc <= nxt == mire_pkg::BURST && state != mire_pkg::IDLE;
      cti <= cti_d;
      frame_done <= accept && last_pixel;
    end
  end
`ifdef MIRE_MOVING_EN
  logic [10:0] frame_cnt;
  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) frame_cnt <= '0;
    else if (accept && last_pixel) frame_cnt <= frame_cnt + 11'd1;
  end
  assign off = frame_cnt[OW-1:0];
`else
  assign off = '0;
`endif
  mire_pattern #(
    .HDISP(HDISP),
    .VDISP(VDISP),
    .GRID (GRID)
  ) u_pattern (
    .pixel_clk (wshb_ifm.clk),
    .pixel_rst (wshb_ifm.rst),
    .advance   (accept),
    .off       (off),
    .rgb       (rgb),
    .last_pixel(last_pixel)
  );
  assign wshb_ifm.cyc = cyc;
  assign wshb_ifm.stb = cyc;
  assign wshb_ifm.adr = 32'({p, 2'b00});
  assign wshb_ifm.dat_ms = {8'h00, rgb};
  assign wshb_ifm.sel = 4'hF;
  assign wshb_ifm.we = 1'b1;
  assign wshb_ifm.cti = cti;
  assign wshb_ifm.bte = 2'b00;
endmodule

// File: tb/tb_mire_writer.sv
// tb_mire_writer: random-ack scoreboard bench for mire_writer on a reduced 64x8 frame
module tb_mire_writer;
  localparam int H = 64;
  localparam int V = 8;
  localparam int B = 16;
  localparam int G = 4;
  localparam int GR = 16;
  localparam int N = H * V;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fd;
  always #5 clk = ~clk;
  wshb_if wif (.clk(clk), .rst(rst));
  mire_writer #(.HDISP(H), .VDISP(V), .BURST(B), .GAP(G), .GRID(GR)) dut (
    .wshb_ifm  (wif),
    .frame_done(fd)
  );
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int vectors = 0;
  int miscompares = 0;
  int p, beat, bursts, frames, gap_left, waits;
  bit fd_exp, stopped;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] pix(input int idx, input int fcount);
    int x, y, off;
    x = idx % H;
    y = idx / H;
`ifdef MIRE_MOVING_EN
    off = fcount % GR;
`else
    off = 0 * fcount;
`endif
    if ((x + off) % GR == 0 || y % GR == 0) return 32'h00FFFFFF;
    return {8'h00, bars[x / (H / 8)]};
  endfunction
  task automatic model_reset();
    p = 0;
    beat = 0;
    frames = 0;
    gap_left = 1;
    fd_exp = 1'b0;
    waits = 0;
  endtask
  task automatic run(input int ncyc, input bit rnd, input int stop_burst, input int stop_beat);
    bit exp_cyc, fin;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_cyc = gap_left == 0;
      chk("cyc", wif.cyc, exp_cyc);
      chk("stb", wif.stb, exp_cyc);
      chk("frame_done", fd, fd_exp);
      fd_exp = 1'b0;
      if (exp_cyc) begin
        if (bursts == stop_burst && beat == stop_beat) begin
          stopped = 1'b1;
          return;
        end
        chk("adr", wif.adr, 32'(p * 4));
        chk("dat_ms", wif.dat_ms, pix(p, frames));
        chk("cti", wif.cti, (beat == B - 1 || p == N - 1) ? 32'd7 : 32'd2);
        if (waits > 0) begin
          wif.ack = 1'b0;
          waits--;
        end else begin
          wif.ack = 1'b1;
          waits = rnd ? $urandom_range(0, 5) : 0;
          fin = beat == B - 1 || p == N - 1;
          if (p == N - 1) begin
            fd_exp = 1'b1;
            frames++;
            p = 0;
          end else p++;
          beat = fin ? 0 : beat + 1;
          if (fin) begin
            gap_left = G;
            bursts++;
          end
        end
      end else begin
        gap_left--;
        wif.ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask
  initial begin
    wif.ack = 1'b0;
    wif.dat_sm = '0;
    bursts = 0;
    stopped = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      chk("rst_cyc", wif.cyc, 0);
      chk("rst_stb", wif.stb, 0);
      chk("rst_adr", wif.adr, 0);
      chk("rst_dat", wif.dat_ms, 32'h00FFFFFF);
      chk("rst_fd", fd, 0);
    end
    chk("rst_cti", wif.cti, 32'd2);
    chk("sel", wif.sel, 32'hF);
    chk("we", wif.we, 1);
    chk("bte", wif.bte, 0);
    rst = 1'b0;
    run(1400, 1'b0, -1, 0);
    run(5000, 1'b1, -1, 0);
    run(3000, 1'b1, bursts + 3, 10);
    chk("reset_point_reached", stopped, 1);
    rst = 1'b1;
    wif.ack = 1'b1;
    @(negedge clk);
    chk("midrst_cyc", wif.cyc, 0);
    chk("midrst_stb", wif.stb, 0);
    chk("midrst_adr", wif.adr, 0);
    chk("midrst_dat", wif.dat_ms, 32'h00FFFFFF);
    chk("midrst_fd", fd, 0);
    rst = 1'b0;
    wif.ack = 1'b0;
    model_reset();
    run(800, 1'b1, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
